// File: rtl/sigma_acc.sv
// sigma_acc: accumulates a valid/ready packet of signed-magnitude terms into one saturated signed-magnitude sum
module sigma_acc #(
  parameter int N  = 16,
  parameter int F  = 8,
  parameter int G  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_sat,
  output logic [CW-1:0] out_count
);
  // F only documents the fixed-point scale; addition does not depend on it
  localparam int AW = N + G + 0 * F;
  localparam logic signed [AW:0] LIM = {2'b00, {(AW-1){1'b1}}};
  typedef enum logic {ACC, HOLD} state_t;
  state_t state, state_nx;
  logic up, acc_ok, isat, sticky, ovf;
  logic [CW-1:0] count, count_nx;
  logic signed [AW-1:0] acc, mag, term, sum_sat;
  logic signed [AW:0] sum;
  logic [AW-1:0] abs_sum;
  logic [N-1:0] res;
  // up keeps in_ready low until the first edge after reset release
  assign in_ready = up && state == ACC;
  assign acc_ok = in_valid && in_ready;
  always_comb begin
    mag = {{(G+1){1'b0}}, in_data[N-2:0]};
    term = in_data[N-1] ? -mag : mag;
    sum = {acc[AW-1], acc} + {term[AW-1], term};
    isat = sum > LIM || sum < -LIM;
    sum_sat = sum > LIM ? LIM[AW-1:0] : sum < -LIM ? -LIM[AW-1:0] : sum[AW-1:0];
    abs_sum = sum_sat[AW-1] ? -sum_sat : sum_sat;
    ovf = |abs_sum[AW-1:N-1];
    res = {sum_sat[AW-1], ovf ? {(N-1){1'b1}} : abs_sum[N-2:0]};
    count_nx = &count ? count : count + CW'(1);
    state_nx = state == ACC ? (acc_ok && in_last ? HOLD : ACC) : (out_ready ? ACC : HOLD);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ACC;
      up <= 1'b0;
      acc <= '0;
      count <= '0;
      sticky <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
      out_count <= '0;
    end else begin
      up <= 1'b1;
      state <= state_nx;
      if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
        acc <= '0;
        count <= '0;
        sticky <= 1'b0;
      end else if (acc_ok) begin
        acc <= sum_sat;
        count <= count_nx;
        sticky <= sticky | isat;
        if (in_last) begin
          out_valid <= 1'b1;
          out_data <= res;
          out_sat <= ovf | sticky | isat;
          out_count <= count_nx;
        end
      end
    end
endmodule

// File: tb/tb_sigma_acc.sv
// tb_sigma_acc: directed and random packets checked against an integer reference sum
module tb_sigma_acc;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [15:0] in_data = 'x;
  logic in_ready, out_valid, out_sat;
  logic [15:0] out_data;
  logic [7:0] out_count;
  int n_cmp = 0, n_err = 0;
  logic [15:0] pk[$];

  always #5 clk = ~clk;

  sigma_acc #(.N(16), .F(8), .G(4), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .out_count(out_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_sum(input logic [15:0] q[$], output logic [15:0] d, output logic s, output logic [7:0] c);
    int acc, m, v;
    acc = 0;
    s = 0;
    foreach (q[i]) begin
      v = int'(q[i][14:0]);
      if (q[i][15]) v = -v;
      acc += v;
      if (acc > 524287) begin acc = 524287; s = 1; end
      if (acc < -524287) begin acc = -524287; s = 1; end
    end
    m = acc < 0 ? -acc : acc;
    if (m > 32767) begin m = 32767; s = 1; end
    d = {acc < 0, m[14:0]};
    c = q.size() > 255 ? 8'd255 : 8'(q.size());
  endtask

  task automatic chk_idle(input string tag, input logic rdy);
    chk({tag, "_in_ready"}, in_ready, rdy);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_sat"}, out_sat, 0);
    chk({tag, "_out_count"}, out_count, 0);
  endtask

  task automatic push(input logic [15:0] d, input logic last);
    chk("push_in_ready", in_ready, 1);
    in_valid = 1;
    in_data = d;
    in_last = last;
    @(negedge clk);
    in_valid = 0;
    in_data = 'x;
    in_last = 1'($urandom_range(0, 1));
  endtask

  task automatic run_pkt(input logic [15:0] q[$], input int hold, input bit gaps);
    logic [15:0] ed;
    logic es;
    logic [7:0] ec;
    ref_sum(q, ed, es, ec);
    foreach (q[i]) begin
      push(q[i], i == q.size() - 1);
      if (i != q.size() - 1) begin
        chk("early_out_valid", out_valid, 0);
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, ed);
    chk("out_sat", out_sat, es);
    chk("out_count", out_count, ec);
    repeat (hold) begin
      in_valid = 1;
      in_data = 16'($urandom);
      in_last = 1;
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_data", out_data, ed);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 0;
    in_data = 'x;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("after_reset_in_ready", in_ready, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_idle("reset", 0);
    release_reset();
    chk_idle("post_reset", 1);
    pk = '{16'h0180, 16'h8080, 16'h0240};
    run_pkt(pk, 0, 0);
    pk = '{16'h8100, 16'h0040};
    run_pkt(pk, 0, 0);
    pk = '{16'h7F00, 16'h7F00};
    run_pkt(pk, 0, 0);
    pk = '{16'hFF00, 16'hFF00};
    run_pkt(pk, 0, 0);
    pk = '{16'h8000};
    run_pkt(pk, 0, 0);
    pk = '{16'h0100, 16'h8100};
    run_pkt(pk, 0, 0);
    pk = '{16'h0123, 16'h8011, 16'h0200};
    run_pkt(pk, 3, 0);
    pk = '{16'h0005};
    run_pkt(pk, 0, 0);
    push(16'h0100, 0);
    push(16'h0100, 0);
    #2 rst_n = 0;
    #1 chk_idle("mid_pkt_reset", 0);
    release_reset();
    pk = '{16'h0080};
    run_pkt(pk, 0, 0);
    push(16'h0100, 1);
    chk("hold_before_reset", out_valid, 1);
    #2 rst_n = 0;
    #1 chk_idle("mid_hold_reset", 0);
    release_reset();
    pk = '{16'h8200};
    run_pkt(pk, 1, 0);
    pk = {};
    repeat (300) pk.push_back(16'h7FFF);
    run_pkt(pk, 0, 0);
    pk = {};
    repeat (20) pk.push_back(16'h7FFF);
    repeat (20) pk.push_back(16'hFFFF);
    run_pkt(pk, 0, 0);
    for (int p = 0; p < 40; p++) begin
      pk = {};
      for (int i = 0, n = $urandom_range(1, 6); i < n; i++)
        pk.push_back($urandom_range(0, 1) ? 16'($urandom) : {1'($urandom), 5'd0, 10'($urandom)});
      run_pkt(pk, $urandom_range(0, 3), 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
